// File: rtl/list_sum_pkg.sv
// list_sum_pkg: select encodings and null-pointer constant shared by the list-sum datapath.
package list_sum_pkg;
  localparam logic SUM_SEL_ZERO  = 1'b0;
  localparam logic SUM_SEL_ACC   = 1'b1;
  localparam logic NEXT_SEL_HEAD = 1'b0;
  localparam logic NEXT_SEL_MEM  = 1'b1;
  localparam logic A_SEL_PTR     = 1'b0;
  localparam logic A_SEL_VAL     = 1'b1;
  localparam int   NULL_PTR      = 0;
endpackage

// File: rtl/list_sum_ram.sv
// list_sum_ram: node memory, synchronous write and asynchronous read (same-cycle read sees the old word).
module list_sum_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/list_sum_datapath.sv
// list_sum_datapath: SUM/NEXT registers, adder and muxes around the node memory for the list-sum FSM.
// Optional pointer-follow limit enabled by defining LIST_SUM_HOP_LIMIT_EN.
module list_sum_datapath
  import list_sum_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 64,
  parameter int MAX_HOPS  = 32,
  localparam int AW       = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [AW-1:0]     head_addr,
  input  logic              LD_SUM,
  input  logic              LD_NEXT,
  input  logic              SUM_SEL,
  input  logic              NEXT_SEL,
  input  logic              A_SEL,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              next_zero,
  output logic [DATA_W-1:0] sum,
  output logic [AW-1:0]     next_ptr,
  output logic              sum_ovf,
  output logic              hop_err
);
  logic [DATA_W-1:0] sum_q, sum_d, acc, rdata;
  logic [AW-1:0]     next_q, next_d, rd_addr;
  logic              ovf_q, ovf_d, carry, ptr_null, ptr_load;

  assign rd_addr = (A_SEL == A_SEL_VAL) ? next_q : next_q + AW'(1);

  list_sum_ram #(.DATA_W(DATA_W), .DEPTH(MEM_DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (rd_addr),
    .rdata_o (rdata)
  );

  assign {carry, acc} = {1'b0, sum_q} + {1'b0, rdata};
  assign ptr_null     = rdata[AW-1:0] == AW'(NULL_PTR);
  assign ptr_load     = LD_NEXT && (NEXT_SEL == NEXT_SEL_MEM);

  always_comb begin
    sum_d  = (SUM_SEL == SUM_SEL_ZERO) ? '0 : acc;
    next_d = (NEXT_SEL == NEXT_SEL_HEAD) ? head_addr : rdata[AW-1:0];
    ovf_d  = ovf_q | (LD_SUM && (SUM_SEL == SUM_SEL_ACC) && carry);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      next_q <= '0;
      ovf_q  <= 1'b0;
    end else if (clear) begin
      sum_q  <= '0;
      next_q <= head_addr;
      ovf_q  <= 1'b0;
    end else begin
      if (LD_SUM) sum_q <= sum_d;
      if (LD_NEXT) next_q <= next_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef LIST_SUM_HOP_LIMIT_EN
  logic [AW:0] hop_q;
  logic        hop_err_q, hop_hit;
  // The limit forces termination but the load itself still happens.
  assign hop_hit = ptr_load && (hop_q == (AW+1)'(MAX_HOPS - 1));
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hop_q     <= '0;
      hop_err_q <= 1'b0;
    end else begin
      if (ptr_load) hop_q <= hop_q + 1'b1;
      hop_err_q <= hop_err_q | (hop_hit & ~ptr_null);
    end
  end
  assign next_zero = ptr_null | hop_hit;
  assign hop_err   = hop_err_q;
`else
  logic unused_hop_cfg;
  assign unused_hop_cfg = ptr_load ^ (MAX_HOPS == 0);
  assign next_zero      = ptr_null;
  assign hop_err        = 1'b0;
`endif

  assign sum      = sum_q;
  assign next_ptr = next_q;
  assign sum_ovf  = ovf_q;
endmodule

// File: tb/tb_list_sum_datapath.sv
// tb_list_sum_datapath: drives FSM-like strobe sequences over small linked lists and
// scoreboards the final sum, pointer, sticky flags, node count and termination per run.
module tb_list_sum_datapath;
  localparam int DW = 16;
  localparam int AW = 6;

  typedef struct {
    logic [DW-1:0] sum;
    logic [AW-1:0] ptr;
    logic          ovf;
    logic          hop;
    int            nodes;
    logic          term;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, clear, LD_SUM, LD_NEXT, SUM_SEL, NEXT_SEL, A_SEL, wr_en;
  logic [AW-1:0] head_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic          next_zero, sum_ovf, hop_err;
  logic [DW-1:0] sum;
  logic [AW-1:0] next_ptr;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  list_sum_datapath #(.DATA_W(DW), .MEM_DEPTH(64), .MAX_HOPS(4)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .head_addr(head_addr),
    .LD_SUM(LD_SUM), .LD_NEXT(LD_NEXT), .SUM_SEL(SUM_SEL), .NEXT_SEL(NEXT_SEL), .A_SEL(A_SEL),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .next_zero(next_zero), .sum(sum), .next_ptr(next_ptr), .sum_ovf(sum_ovf), .hop_err(hop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  function automatic exp_t mk(input logic [DW-1:0] s, input logic [AW-1:0] p, input logic o,
                              input logic h, input int n, input logic t);
    exp_t e;
    e.sum = s; e.ptr = p; e.ovf = o; e.hop = h; e.nodes = n; e.term = t;
    return e;
  endfunction

  // One clear followed by up to maxn COMPUTE_SUM/GET_NEXT pairs; optional write on GET_NEXT #coll_n.
  task automatic run_list(input string tag, input logic [AW-1:0] head, input int maxn, input exp_t e,
                          input int coll_n, input logic [AW-1:0] coll_a, input logic [DW-1:0] coll_d);
    int   nodes;
    logic term;
    exp_t x;
    exp_q.push_back(e);
    clear = 1'b1; head_addr = head;
    step();
    clear = 1'b0;
    nodes = 0; term = 1'b0;
    for (int i = 0; i < maxn && !term; i++) begin
      A_SEL = 1'b1; LD_SUM = 1'b1; SUM_SEL = 1'b1;
      step();
      LD_SUM = 1'b0;
      A_SEL = 1'b0; LD_NEXT = 1'b1; NEXT_SEL = 1'b1;
      if (i == coll_n) begin
        wr_en = 1'b1; wr_addr = coll_a; wr_data = coll_d;
      end
      #1 term = next_zero;
      step();
      LD_NEXT = 1'b0; wr_en = 1'b0;
      nodes++;
    end
    x = exp_q.pop_front();
    chk({tag, ".sum"},   32'(sum),      32'(x.sum));
    chk({tag, ".ptr"},   32'(next_ptr), 32'(x.ptr));
    chk({tag, ".ovf"},   32'(sum_ovf),  32'(x.ovf));
    chk({tag, ".hop"},   32'(hop_err),  32'(x.hop));
    chk({tag, ".nodes"}, 32'(nodes),    32'(x.nodes));
    chk({tag, ".term"},  32'(term),     32'(x.term));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; LD_SUM = 1'b0; LD_NEXT = 1'b0; SUM_SEL = 1'b0; NEXT_SEL = 1'b0;
    A_SEL = 1'b0; wr_en = 1'b0; head_addr = '0; wr_addr = '0; wr_data = '0;
    step(); step();
    rst = 1'b0;
    chk("rst.sum", 32'(sum), 0);
    chk("rst.ptr", 32'(next_ptr), 0);
    chk("rst.ovf", 32'(sum_ovf), 0);
    chk("rst.hop", 32'(hop_err), 0);

    wr(2, 5);  wr(3, 6);  wr(6, 7);  wr(7, 10); wr(10, 9); wr(11, 0);
    run_list("l3", 2, 10, mk(21, 0, 0, 0, 3, 1), -1, 0, 0);

    // pointer words carry junk in the upper bits
    wr(20, 100); wr(21, 16'h7F18); wr(24, 3); wr(25, 16'hFFC0);
    run_list("upper", 20, 10, mk(103, 0, 0, 0, 2, 1), -1, 0, 0);

    // pointer word of node 63 lives at address 0
    wr(0, 0); wr(63, 11);
    run_list("wrap", 63, 10, mk(11, 0, 0, 0, 1, 1), -1, 0, 0);

    wr(30, 16'd65000); wr(31, 34); wr(34, 16'd1000); wr(35, 0);
    run_list("ovf", 30, 10, mk(16'd464, 0, 1, 0, 2, 1), -1, 0, 0);
    LD_SUM = 1'b1; SUM_SEL = 1'b0;
    step();
    LD_SUM = 1'b0;
    chk("ovf.zload.sum", 32'(sum), 0);
    chk("ovf.held", 32'(sum_ovf), 1);
    clear = 1'b1; head_addr = 2;
    step();
    clear = 1'b0;
    chk("ovf.clr", 32'(sum_ovf), 0);
    chk("ovf.clr.ptr", 32'(next_ptr), 2);

    // second GET_NEXT reads address 7 while it is overwritten
    run_list("coll", 2, 10, mk(21, 0, 0, 0, 3, 1), 1, 7, 0);
    run_list("coll.rerun", 2, 10, mk(12, 0, 0, 0, 2, 1), -1, 0, 0);
    wr(7, 10);

    clear = 1'b1; head_addr = 2;
    step();
    clear = 1'b0;
    A_SEL = 1'b1; LD_SUM = 1'b1; SUM_SEL = 1'b1;
    step();
    LD_SUM = 1'b0; A_SEL = 1'b0; LD_NEXT = 1'b1; NEXT_SEL = 1'b1;
    step();
    LD_NEXT = 1'b0; A_SEL = 1'b1; LD_SUM = 1'b1; clear = 1'b1;
    step();
    LD_SUM = 1'b0; clear = 1'b0;
    chk("midclr.sum", 32'(sum), 0);
    chk("midclr.ptr", 32'(next_ptr), 2);
    run_list("midclr.rerun", 2, 10, mk(21, 0, 0, 0, 3, 1), -1, 0, 0);

    clear = 1'b1; head_addr = 2;
    step();
    clear = 1'b0;
    A_SEL = 1'b1; LD_SUM = 1'b1; SUM_SEL = 1'b1;
    step();
    LD_SUM = 1'b0; A_SEL = 1'b0; LD_NEXT = 1'b1; NEXT_SEL = 1'b1;
    step();
    LD_NEXT = 1'b0;
    chk("midrst.pre.sum", 32'(sum), 5);
    chk("midrst.pre.ptr", 32'(next_ptr), 6);
    A_SEL = 1'b1; LD_SUM = 1'b1; rst = 1'b1;
    step();
    LD_SUM = 1'b0; rst = 1'b0;
    chk("midrst.sum", 32'(sum), 0);
    chk("midrst.ptr", 32'(next_ptr), 0);
    chk("midrst.ovf", 32'(sum_ovf), 0);
    chk("midrst.hop", 32'(hop_err), 0);
    run_list("midrst.rerun", 2, 10, mk(21, 0, 0, 0, 3, 1), -1, 0, 0);

    // node 4 points to itself
    wr(4, 1); wr(5, 4);
`ifdef LIST_SUM_HOP_LIMIT_EN
    run_list("cyc", 4, 10, mk(4, 4, 0, 1, 4, 1), -1, 0, 0);
    clear = 1'b1; head_addr = 2;
    step();
    clear = 1'b0;
    chk("cyc.clr.hop", 32'(hop_err), 0);
`else
    run_list("cyc", 4, 6, mk(6, 4, 0, 0, 6, 0), -1, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
